// File: rtl/ultra_sonic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ultra_sonic_pkg : states, default timings and helpers for responder |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ultra_sonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG_HIGH = 3'd1,
    ST_BURST     = 3'd2,
    ST_ECHO      = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  localparam int DEF_MIN_TRIG    = 500;
  localparam int DEF_BURST_DELAY = 23000;
  localparam int DEF_NO_OBJ_LEN  = 1900000;
  localparam int DEF_HOLDOFF     = 50000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ultra_sonic_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ultra_sonic_responder_if : GPIO-side and config signals            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ultra_sonic_responder_if;
  logic        trigger;
  logic        echo;
  logic [15:0] cfg_len;
  logic        cfg_we;
  logic        busy;
  logic        echo_done;
  logic [7:0]  runt_count;

  modport slave (
    input  trigger, cfg_len, cfg_we,
    output echo, busy, echo_done, runt_count
  );

  modport master (
    output trigger, cfg_len, cfg_we,
    input  echo, busy, echo_done, runt_count
  );
endinterface
`default_nettype wire

// File: rtl/ultra_sonic_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ultra_sonic_sync : 2-flop synchronizer for the GPIO trigger        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ultra_sonic_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/ultra_sonic_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ultra_sonic_responder : HC-SR04 style trigger/echo sensor emulator |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ultra_sonic_responder
  import ultra_sonic_pkg::*;
#(
  parameter int MIN_TRIG    = DEF_MIN_TRIG,
  parameter int BURST_DELAY = DEF_BURST_DELAY,
  parameter int NO_OBJ_LEN  = DEF_NO_OBJ_LEN,
  parameter int HOLDOFF     = DEF_HOLDOFF
) (
  input  logic                    clk,
  input  logic                    reset,
  ultra_sonic_responder_if.slave  bus
);
  localparam int TRIG_W = max_int(1, $clog2(MIN_TRIG + 1));
  localparam int CNT_W  = max_int(24, max_int($clog2(NO_OBJ_LEN + 1),
                          max_int($clog2(BURST_DELAY + 1), $clog2(HOLDOFF + 1))));

  localparam logic [TRIG_W-1:0] TRIG_ONE     = TRIG_W'(1);
  localparam logic [TRIG_W-1:0] TRIG_MAX     = TRIG_W'(MIN_TRIG);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  BURST_LAST   = CNT_W'(BURST_DELAY - 1);
  localparam logic [CNT_W-1:0]  NO_OBJ_LAST  = CNT_W'(NO_OBJ_LEN - 1);
  localparam logic [CNT_W-1:0]  HOLDOFF_LAST = CNT_W'(HOLDOFF - 1);

  logic              trig_s;
  logic              trig_prev_q;
  state_e            state_q;
  logic [TRIG_W-1:0] trig_cnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  echo_last;
  logic [15:0]       len_shadow_q;
  logic [15:0]       len_q;
  logic [7:0]        runt_q;
  logic              echo_q;
  logic              busy_q;
  logic              done_q;

  ultra_sonic_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.trigger),
    .q_o   (trig_s)
  );

  // Echo length is len_q * 256 cycles; a zero length means "nothing in range".
  always_comb begin
    echo_last = NO_OBJ_LAST;
    if (len_q != 16'd0) echo_last = CNT_W'({len_q, 8'h00}) - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      trig_cnt_q   <= '0;
      cnt_q        <= '0;
      len_shadow_q <= '0;
      len_q        <= '0;
      runt_q       <= '0;
      echo_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      trig_prev_q <= trig_s;
      done_q      <= 1'b0;
      if (bus.cfg_we) len_shadow_q <= bus.cfg_len;

      case (state_q)
        ST_IDLE: begin
          if (trig_s && !trig_prev_q) begin
            state_q    <= ST_TRIG_HIGH;
            trig_cnt_q <= TRIG_ONE;
            busy_q     <= 1'b1;
          end
        end
        ST_TRIG_HIGH: begin
          if (trig_s) begin
            if (trig_cnt_q < TRIG_MAX) trig_cnt_q <= trig_cnt_q + TRIG_ONE;
          end else if (trig_cnt_q >= TRIG_MAX) begin
            state_q <= ST_BURST;
            len_q   <= len_shadow_q;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (runt_q != 8'hFF) runt_q <= runt_q + 8'd1;
          end
        end
        ST_BURST: begin
          if (cnt_q == BURST_LAST) begin
            state_q <= ST_ECHO;
            echo_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_ECHO: begin
          if (cnt_q == echo_last) begin
            state_q <= ST_HOLDOFF;
            echo_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (cnt_q == HOLDOFF_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          echo_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.echo       = echo_q;
  assign bus.busy       = busy_q;
  assign bus.echo_done  = done_q;
  assign bus.runt_count = runt_q;
endmodule
`default_nettype wire

// File: tb/tb_ultra_sonic_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ultra_sonic_responder : directed self-checking bench            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ultra_sonic_responder;
  localparam int P_MIN = 8;
  localparam int P_BD  = 20;
  localparam int P_NO  = 300;
  localparam int P_HO  = 30;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat, width, dones;
  int   seen;

  always #5 clk = ~clk;

  ultra_sonic_responder_if bus ();

  ultra_sonic_responder #(
    .MIN_TRIG    (P_MIN),
    .BURST_DELAY (P_BD),
    .NO_OBJ_LEN  (P_NO),
    .HOLDOFF     (P_HO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_cfg(input logic [15:0] v);
    @(negedge clk);
    bus.cfg_len = v;
    bus.cfg_we  = 1'b1;
    @(negedge clk);
    bus.cfg_we  = 1'b0;
  endtask

  task automatic fire(input int n);
    @(negedge clk);
    bus.trigger = 1'b1;
    repeat (n) @(negedge clk);
    bus.trigger = 1'b0;
  endtask

  // Called right after the trigger falls: measures rise latency, width and done pulses.
  task automatic run_echo(input int wr_at, input logic [15:0] wr_val, input int tog_a,
                          input int tog_b, input int hold_at,
                          output int o_lat, output int o_width, output int o_dones);
    o_lat = 0; o_width = 0; o_dones = 0;
    while (1) begin
      @(posedge clk); #1;
      o_lat++;
      o_dones += int'(bus.echo_done);
      if (bus.echo) break;
      if (o_lat >= 200) begin o_lat = -1; return; end
    end
    o_width = 1;
    while (1) begin
      if (o_width == wr_at) begin bus.cfg_len = wr_val; bus.cfg_we = 1'b1; end
      else bus.cfg_we = 1'b0;
      if (o_width == tog_a)   bus.trigger = 1'b1;
      if (o_width == tog_b)   bus.trigger = 1'b0;
      if (o_width == hold_at) bus.trigger = 1'b1;
      @(posedge clk); #1;
      o_dones += int'(bus.echo_done);
      if (!bus.echo) break;
      o_width++;
      if (o_width > 6000) break;
    end
    bus.cfg_we = 1'b0;
    @(posedge clk); #1;
    o_dones += int'(bus.echo_done);
  endtask

  initial begin
    bus.trigger = 1'b0;
    bus.cfg_len = '0;
    bus.cfg_we  = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_echo", 32'(bus.echo), 0);
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_done", 32'(bus.echo_done), 0);
    check_val("rst_runt", 32'(bus.runt_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Programmed object: 16 * 256 cycles
    write_cfg(16'h0010);
    fire(12);
    run_echo(-1, 16'h0, -1, -1, -1, lat, width, dones);
    check_val("lat16", 32'(lat), 32'(P_BD + 3));
    check_val("width16", 32'(width), 4096);
    check_val("done16", 32'(dones), 1);
    check_val("busy_holdoff", 32'(bus.busy), 1);
    repeat (P_HO + 5) @(negedge clk);
    check_val("busy_after_ho", 32'(bus.busy), 0);

    // No object
    write_cfg(16'h0000);
    fire(12);
    run_echo(-1, 16'h0, -1, -1, -1, lat, width, dones);
    check_val("width_noobj", 32'(width), P_NO);
    check_val("done_noobj", 32'(dones), 1);
    repeat (P_HO + 5) @(negedge clk);

    // Runt triggers
    fire(4);
    seen = 0;
    repeat (4) begin @(posedge clk); #1; seen += int'(bus.echo); end
    check_val("runt_busy", 32'(bus.busy), 0);
    check_val("runt_cnt1", 32'(bus.runt_count), 1);
    check_val("runt_noecho", 32'(seen), 0);
    repeat (254) begin fire(4); repeat (6) @(negedge clk); end
    check_val("runt_cnt255", 32'(bus.runt_count), 255);
    fire(4); repeat (6) @(negedge clk);
    check_val("runt_sat", 32'(bus.runt_count), 255);

    // Config written mid-echo only affects the next measurement
    write_cfg(16'd5);
    fire(12);
    run_echo(100, 16'd9, -1, -1, -1, lat, width, dones);
    check_val("width5", 32'(width), 1280);
    repeat (P_HO + 5) @(negedge clk);
    fire(12);
    run_echo(-1, 16'h0, -1, -1, -1, lat, width, dones);
    check_val("width9", 32'(width), 2304);
    repeat (P_HO + 5) @(negedge clk);

    // Trigger activity during echo and held high across holdoff end
    write_cfg(16'd2);
    fire(12);
    run_echo(-1, 16'h0, 50, 70, 200, lat, width, dones);
    check_val("width_glitch", 32'(width), 512);
    check_val("done_glitch", 32'(dones), 1);
    seen = 0;
    repeat (P_HO + 20) begin @(posedge clk); #1; seen += int'(bus.echo); end
    check_val("held_noecho", 32'(seen), 0);
    check_val("held_busy", 32'(bus.busy), 0);
    check_val("held_runt", 32'(bus.runt_count), 255);
    @(negedge clk);
    bus.trigger = 1'b0;
    repeat (5) @(negedge clk);
    fire(12);
    run_echo(-1, 16'h0, -1, -1, -1, lat, width, dones);
    check_val("lat_after_held", 32'(lat), 32'(P_BD + 3));
    check_val("width_after_held", 32'(width), 512);
    repeat (P_HO + 5) @(negedge clk);

    // Reset in the middle of an echo
    write_cfg(16'h0010);
    fire(12);
    seen = 0;
    while (!bus.echo && seen < 200) begin @(posedge clk); #1; seen++; end
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_echo", 32'(bus.echo), 0);
    check_val("mid_rst_busy", 32'(bus.busy), 0);
    check_val("mid_rst_runt", 32'(bus.runt_count), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; seen += int'(bus.echo_done) + int'(bus.echo); end
    check_val("mid_rst_nodone", 32'(seen), 0);
    fire(12);
    run_echo(-1, 16'h0, -1, -1, -1, lat, width, dones);
    check_val("width_shadow_rst", 32'(width), P_NO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ultra_sonic_responder.md
ULTRA_SONIC_RESPONDER -- requirements
Module: ultra_sonic_responder

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be: MIN_TRIG, default 500, minimum valid trigger width in cycles (10 us at 50 MHz). BURST_DELAY, default 23000, trigger-fall-to-echo-rise delay in cycles. NO_OBJ_LEN, default 1900000, echo width in cycles when no object is programmed. HOLDOFF, default 50000, post-echo dead time in cycles.
REQ-003 Ports SHALL be:
  clk  input  1  50 MHz clock.
  reset  input  1  synchronous active-high reset.
  trigger  input  1  from GPIO, asynchronous to clk.
  echo  output  1  to GPIO, registered.
  cfg_len  input  16  echo width in units of 256 cycles; 0 = no object.
  cfg_we  input  1  single-cycle write strobe for cfg_len.
  busy  output  1  high in every state except IDLE.
  echo_done  output  1  single-cycle pulse on echo falling edge.
  runt_count  output  8  count of rejected short triggers, saturating.

Function
REQ-004 trigger SHALL pass through a 2-flop synchronizer to form trig_s; every reference below to trigger means trig_s.
REQ-005 cfg_we=1 SHALL load cfg_len into len_shadow on the same edge; len_shadow SHALL reset to 0.
REQ-006 States SHALL be IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
REQ-007 IDLE -> TRIG_HIGH SHALL occur only on a trig_s rising edge (trig_s=1 with its previous value 0); a trigger already high on IDLE entry SHALL NOT start a cycle.
REQ-008 In TRIG_HIGH, trig_cnt SHALL count cycles with trig_s=1 and saturate at MIN_TRIG.
REQ-009 On trig_s=0 in TRIG_HIGH: if trig_cnt>=MIN_TRIG, go to BURST; otherwise go to IDLE and increment runt_count, which saturates at 255.
REQ-010 Entry to BURST SHALL latch len_q from len_shadow; a cfg_we during BURST, ECHO or HOLDOFF SHALL affect only the next measurement.
REQ-011 BURST SHALL last exactly BURST_DELAY cycles and then go to ECHO.
REQ-012 In ECHO, echo SHALL be high for exactly len_q*256 cycles (24-bit counter, len_q<<8), or NO_OBJ_LEN cycles when len_q=0.
REQ-013 When the echo period ends, echo SHALL fall, echo_done SHALL pulse for 1 cycle, and the state SHALL go to HOLDOFF.
REQ-014 HOLDOFF SHALL last HOLDOFF cycles with trigger ignored, then go to IDLE.
REQ-015 Trigger activity in BURST, ECHO or HOLDOFF SHALL be ignored: no runt increment and no restart.
REQ-016 echo SHALL be 1 only in ECHO; busy SHALL be 0 only in IDLE.
REQ-017 Echo-rise latency SHALL be 2 synchronizer cycles after trigger falls, plus 1 cycle state update, plus BURST_DELAY.
REQ-018 Round-trip: a controller that counts echo-high cycles and shifts the count right by 8 SHALL read back cfg_len exactly.

Reset
REQ-019 While reset=1, on each clk edge the block SHALL set state to IDLE, echo=0, busy=0, echo_done=0, runt_count=0, all counters to 0, len_shadow=0, len_q=0 and the synchronizer flops to 0.
REQ-020 Reset asserted mid-echo SHALL drop echo on the next edge, and SHALL NOT generate an echo_done pulse.

Structure
REQ-021 Package ultra_sonic_pkg SHALL hold the state enum and the default values of MIN_TRIG, BURST_DELAY, NO_OBJ_LEN and HOLDOFF.
REQ-022 Sub-module ultra_sonic_sync SHALL implement the 2-flop synchronizer; all other logic SHALL stay in ultra_sonic_responder.
REQ-023 Counter widths SHALL be derived with $clog2 from the parameters; the echo counter SHALL be at least 24 bits wide.

Verification
REQ-024 cfg_len=0x0010, 600-cycle trigger -> echo rises BURST_DELAY+3 cycles after trigger falls and stays high exactly 4096 cycles; echo_done pulses once.
REQ-025 cfg_len=0, valid trigger -> echo high exactly 1900000 cycles.
REQ-026 300-cycle trigger -> no echo, runt_count=1, busy back to 0 within 4 cycles; 256 runts -> runt_count stays 255.
REQ-027 cfg_len=5 written, trigger, then cfg_len=9 written during ECHO -> first echo 1280 cycles, next echo 2304 cycles.
REQ-028 Trigger pulses during ECHO and HOLDOFF, trigger held high across HOLDOFF end -> no restart until the next rising edge.
REQ-029 Reset asserted mid-ECHO -> echo=0 next cycle, state IDLE, no echo_done pulse.
